// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: request/result bundle for the iterative divider.
// master = issuing core side, slave = divider; start/op/operands in, busy/valid/result out.
interface div_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, dividend, divisor, out_ready,
    input  busy, out_valid, result
  );

  modport slave (
    input  start, op, dividend, divisor, out_ready,
    output busy, out_valid, result
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: radix-2 restoring DIV/DIVU/REM/REMU with IDLE/CALC/FIX/DONE sequencer.
// Ports: clk, rst_n (async low), bus (slave), flush only when DIV_FLUSH_EN is defined.
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DIV_FLUSH_EN
  input  logic flush,
`endif
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  logic fl;
`ifdef DIV_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] res_q;
  logic             q_neg, r_neg;
  logic             dz, ovf;

  // op[0]=0 selects the signed forms (DIV/REM)
  logic sgn, a_neg, b_neg;
  logic dz_in, ovf_in;
  assign sgn    = ~bus.op[0];
  assign a_neg  = sgn & bus.dividend[WIDTH-1];
  assign b_neg  = sgn & bus.divisor[WIDTH-1];
  assign dz_in  = (bus.divisor == '0);
  assign ovf_in = sgn & (bus.dividend == MIN)
                & (bus.divisor == '1);

  // shifted partial remainder can exceed WIDTH
  // bits for large unsigned divisors
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] trial;
  assign sh    = {rem, quot[WIDTH-1]};
  assign trial = {1'b0, sh} - {2'b0, dvsr};

  logic unused_trial;
  assign unused_trial = trial[WIDTH];

  logic [WIDTH-1:0] q_sel, r_sel;
  always_comb begin
    q_sel = q_neg ? -quot : quot;
    r_sel = r_neg ? -rem : rem;
    if (dz) begin
      q_sel = '1;
      r_sel = dvd_q;
    end else if (ovf) begin
      q_sel = MIN;
      r_sel = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start)
        state_nxt = (dz_in | ovf_in) ? FIX : CALC;
      CALC: if (cnt == LAST)
        state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready)
        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (fl) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      op_q  <= '0;
      dvd_q <= '0;
      dvsr  <= '0;
      rem   <= '0;
      quot  <= '0;
      res_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else if (!fl) begin
      unique case (state)
        IDLE: if (bus.start) begin
          op_q  <= bus.op;
          dvd_q <= bus.dividend;
          dvsr  <= b_neg ? -bus.divisor
                         : bus.divisor;
          quot  <= a_neg ? -bus.dividend
                         : bus.dividend;
          rem   <= '0;
          cnt   <= '0;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          dz    <= dz_in;
          ovf   <= ovf_in;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH+1]) begin
            rem  <= trial[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= sh[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
        end
        FIX: res_q <= op_q[1] ? r_sel : q_sel;
        DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed vector table plus protocol sequences
// for div_seq_ctrl (latency, backpressure, reset, optional flush).
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef DIV_FLUSH_EN
  logic flush = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  div_seq_ctrl_if #(.WIDTH(W)) bus ();

  div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef DIV_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // latency = edges from the start edge through
  // the edge that enters DONE, inclusive
  task automatic do_op(input logic [1:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output logic [W-1:0] r,
                       output int lat,
                       output logic idle);
    @(negedge clk);
    bus.op = o;
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    bus.out_ready = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 100);
    r = bus.result;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    idle = !bus.busy && !bus.out_valid;
  endtask

  initial begin
    logic [W-1:0] r;
    int lat;
    logic idle;
    int bc;
    int bad;
    logic [W-1:0] res;

    vecs[0]  = '{2'd1, 32'd100, 32'd7, 32'd14, 34};
    vecs[1]  = '{2'd3, 32'd100, 32'd7, 32'd2, 34};
    vecs[2]  = '{2'd0, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFD, 34};
    vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 34};
    vecs[4]  = '{2'd2, 32'd7, 32'hFFFFFFFE,
                 32'd1, 34};
    vecs[5]  = '{2'd0, 32'h80000000, 32'd1,
                 32'h80000000, 34};
    vecs[6]  = '{2'd1, 32'h1234, 32'd0,
                 32'hFFFFFFFF, 2};
    vecs[7]  = '{2'd2, 32'h1234, 32'd0,
                 32'h1234, 2};
    vecs[8]  = '{2'd0, 32'hFFFFFFFB, 32'd0,
                 32'hFFFFFFFF, 2};
    vecs[9]  = '{2'd0, 32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 2};
    vecs[10] = '{2'd2, 32'h80000000, 32'hFFFFFFFF,
                 32'd0, 2};
    vecs[11] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'd1, 34};
    vecs[12] = '{2'd3, 32'hFFFFFFFE, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 34};
    vecs[13] = '{2'd1, 32'hFFFFFFFF, 32'd10,
                 32'h19999999, 34};
    vecs[14] = '{2'd0, 32'd7, 32'hFFFFFFFE,
                 32'hFFFFFFFD, 34};
    vecs[15] = '{2'd3, 32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 34};

    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b,
            r, lat, idle);
      chk($sformatf("vec%0d_result", i),
          r, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i),
          32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_idle", i),
          32'(idle), 32'd1);
    end

    // busy span with out_ready held high
    @(negedge clk);
    bus.op = 2'd1;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    bc = 0;
    res = '0;
    do begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bc++;
      if (bus.out_valid) res = bus.result;
    end while (bus.busy && bc < 100);
    chk("busy_span", 32'(bc), 32'd35);
    chk("busy_span_result", res, 32'd14);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // backpressure in DONE with start pulses
    bus.op = 2'd1;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd10;
    bus.start = 1'b1;
    bc = 0;
    do begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bc++;
    end while (!bus.out_valid && bc < 100);
    chk("bp_latency", 32'(bc), 32'd34);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = (i % 2) == 0;
      bus.op = 2'd3;
      bus.dividend = 32'd55;
      bus.divisor = 32'd4;
      @(posedge clk);
      #1;
      if (!(bus.out_valid && bus.busy
            && bus.result == 32'd100))
        bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_accept_busy", 32'(bus.busy), 32'd0);
    chk("bp_accept_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_result_hold", bus.result, 32'd100);
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_no_restart", 32'(bus.busy), 32'd0);

    // async reset in the middle of CALC
    @(negedge clk);
    bus.op = 2'd1;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) bad++;
    end
    chk("mid_rst_stray", 32'(bad), 32'd0);

`ifdef DIV_FLUSH_EN
    @(negedge clk);
    bus.op = 2'd1;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd10;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_result", bus.result, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) bad++;
    end
    chk("flush_stray", 32'(bad), 32'd0);
    do_op(2'd1, 32'd9, 32'd3, r, lat, idle);
    chk("flush_next_result", r, 32'd3);
    chk("flush_next_latency", 32'(lat), 32'd34);

    @(negedge clk);
    bus.op = 2'd1;
    bus.dividend = 32'd9;
    bus.divisor = 32'd3;
    bus.start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_start_idle", 32'(bus.busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Iterative radix-2 restoring divider with its own sequencer. It computes DIV, DIVU, REM and REMU for the M-extension in place of the single-cycle divide path.
- Sits beside the ALU in the execute stage. The core holds the pipeline while `busy` is high and takes the result through a valid/ready handshake.
- Corner-case results follow the RISC-V spec for divide-by-zero and signed overflow.

Parameters:
- `WIDTH`, 32, operand/result width in bits. Must be a power of two, 8 or more.
- `CNT_W`, 6, iteration counter width. Must satisfy 2^`CNT_W` > `WIDTH`.

Ports:
- `clk`  input  1  core clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request a new operation. Sampled only in IDLE.
- `op`  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `dividend`  input  `WIDTH`  numerator. Sampled with `start`.
- `divisor`  input  `WIDTH`  denominator. Sampled with `start`.
- `busy`  output  1  high in every state except IDLE.
- `out_valid`  output  1  result available (DONE state).
- `out_ready`  input  1  consumer accepts the result.
- `result`  output  `WIDTH`  quotient or remainder, selected by the latched `op`.
- `flush`  input  1  abort. Present only with `DIV_FLUSH_EN`.

Behaviour:
- Reset (`rst_n` low, asynchronous): state=IDLE, `busy`=0, `out_valid`=0, `result`=0, counter=0, all internal registers 0. Reset mid-operation discards the operation. No result is produced after `rst_n` rises.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1 at a rising edge latches `op`, `dividend` and `divisor`.
  - Signed ops (DIV/REM): store operand magnitudes; record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend).
  - Next state:
    - `divisor`==0 → FIX (special case).
    - Signed op with `dividend`=most-negative and `divisor`=−1 → FIX (special case).
    - Otherwise → CALC with counter=0.
- CALC:
  - One restoring step per cycle: shift {rem,quot} left by 1; trial = rem − divisor magnitude; if trial is non-negative, rem=trial and quot LSB=1.
  - Counter increments each cycle. After `WIDTH` steps (counter reaches `WIDTH`−1 in the final step) → FIX.
  - `start` is ignored while `busy`.
- FIX (one cycle):
  - Apply sign correction: negate quotient and/or remainder per the recorded signs.
  - Divide-by-zero overrides: quotient=all ones; remainder=dividend, unmodified.
  - Signed-overflow overrides: quotient=most-negative; remainder=0.
  - Register `result` per `op`.
  - Next state → DONE.
- DONE:
  - `out_valid`=1 and `result` are held stable until `out_ready`=1 at an edge, then → IDLE with `out_valid`=0.
  - `start` in DONE is ignored. No back-to-back acceptance in the same cycle as `out_ready`.
- Latency, counted from the `start` edge to the first `out_valid` cycle:
  - normal: `WIDTH`+2 cycles (34 at `WIDTH`=32).
  - special cases: 2 cycles.
- Widths: all datapath arithmetic is `WIDTH`+1 bits so the trial-subtract borrow is visible. Magnitude of most-negative is 2^(`WIDTH`−1), representable unsigned.
- `result` changes only on the FIX→DONE transition or reset.

Optional Feature:
- Macro `DIV_FLUSH_EN`.
- Defined: `flush` port exists.
  - `flush`=1 at an edge in any state forces IDLE, `out_valid`=0 and `busy`=0 in the following cycle. Internal registers keep their values and `result` holds.
  - `flush` has priority over `start` and `out_ready` in the same cycle.
  - `flush`=1 in IDLE with `start`=1 means the start is not accepted.
- Undefined: no `flush` port. The operation always runs to DONE and can only be cancelled by `rst_n`.

Test Plan:
- DIVU 100/7, then REMU 100/7 → result 14 and 2. `out_valid` rises 34 cycles after `start`; `busy` high for exactly 35 cycles with `out_ready` tied 1.
- DIV −7/2 → −3 (0xFFFFFFFD). REM −7/2 → −1. REM 7/−2 → 1. DIV 0x80000000/1 → 0x80000000.
- Divisor 0: DIVU 0x1234/0 → 0xFFFFFFFF; REM 0x1234/0 → 0x1234; DIV −5/0 → 0xFFFFFFFF. Each returns in 2 cycles.
- Overflow: DIV 0x80000000/−1 → 0x80000000; REM → 0. Returns in 2 cycles.
- Backpressure and protocol:
  - Hold `out_ready`=0 for 10 cycles in DONE → `result` and `out_valid` stable, `start` pulses ignored.
  - Assert `out_ready` → IDLE next cycle.
  - Pulse `rst_n` low at CALC cycle 15 → all outputs 0 immediately; no stray `out_valid` after release.
- With `DIV_FLUSH_EN`:
  - `flush` at CALC cycle 10 → IDLE next cycle, no `out_valid`. A new DIVU 9/3 then returns 3.
  - `flush` with `start` in IDLE → start not accepted.
